// File: rtl/secure_mem_host.sv
// secure_mem_host
// Host-side initiator for the password-gated RAM/ROM store. It takes single
// read/write requests, checks the caller's key locally, drives the
// password/data/strobe sequence the store expects, and returns a one-cycle
// response. After MAX_FAIL consecutive key failures it locks out until
// unlock (in IDLE) or rst.
//
// State table
//   IDLE    | ready for a request; unlock clears the failure counter
//   CHECK   | compare the latched key; decide error or bus access
//   SEL     | password and data presented on the memory bus
//   MODE    | read: mem_re pulse; write: one more setup cycle
//   ACC     | write strobe (writes only)
//   WAIT_RD | wait RD_LAT cycles, capture mem_rdata on the last edge
//   RESP    | one-cycle rsp_valid pulse
//   GAP     | idle bus for GAP_CYC cycles after a bus transaction
//
// Ports
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_rom       operation and target
//   req_key, req_wdata       caller key and write data
//   unlock                   clears the failure counter (IDLE only)
//   rsp_valid/rsp_err/rsp_rdata  one-cycle response
//   locked, fail_cnt         lockout status
//   mem_pw, mem_data, mem_we, mem_re, mem_rdata  memory bus
module secure_mem_host #(
  parameter logic [5:0]  RAM_KEY  = 6'h3F,
  parameter logic [5:0]  ROM_KEY  = 6'h3E,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_rom,
  input  logic [5:0] req_key,
  input  logic [7:0] req_wdata,
  input  logic       unlock,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       locked,
  output logic [2:0] fail_cnt,
  output logic [7:0] mem_pw,
  output logic [7:0] mem_data,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);

  localparam logic [2:0] MAX_FAIL_C = MAX_FAIL[2:0];
  localparam logic [1:0] RD_LAT_M1  = 2'(RD_LAT - 1);
  localparam logic [1:0] GAP_M1     = 2'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SEL, S_MODE, S_ACC, S_WAIT_RD, S_RESP, S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic       write_q, rom_q, err_q;
  logic [5:0] key_q;
  logic [7:0] wdata_q, rdata_q;
  logic [1:0] cnt_q;
  logic [2:0] fail_q;
  logic       key_bad, bus_en;

  assign locked   = (fail_q == MAX_FAIL_C);
  assign fail_cnt = fail_q;
  assign key_bad  = (key_q != (rom_q ? ROM_KEY : RAM_KEY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 8'h00;
    mem_pw    = 8'h00;
    mem_data  = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    bus_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst gating keeps ready low while reset is held
        req_ready = !unlock && !rst;
        if (req_valid && req_ready) state_d = S_CHECK;
      end
      S_CHECK: state_d = (locked || key_bad) ? S_RESP : S_SEL;
      S_SEL: begin
        bus_en  = 1'b1;
        state_d = S_MODE;
      end
      S_MODE: begin
        bus_en  = 1'b1;
        mem_re  = !write_q;
        state_d = write_q ? S_ACC : S_WAIT_RD;
      end
      S_ACC: begin
        bus_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = S_RESP;
      end
      S_WAIT_RD: begin
        bus_en = 1'b1;
        if (cnt_q == 2'd0) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        state_d   = err_q ? S_IDLE : S_GAP;
      end
      S_GAP: if (cnt_q == 2'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus_en) begin
      mem_pw   = {~rom_q, ~write_q, key_q};
      mem_data = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      rom_q   <= 1'b0;
      key_q   <= 6'h00;
      wdata_q <= 8'h00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      cnt_q   <= 2'd0;
      fail_q  <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (unlock) begin
            fail_q <= 3'd0;
          end else if (req_valid) begin
            write_q <= req_write;
            rom_q   <= req_rom;
            key_q   <= req_key;
            wdata_q <= req_wdata;
          end
        end
        S_CHECK: begin
          // rdata cleared here so writes and errors respond with 0
          rdata_q <= 8'h00;
          if (locked) begin
            err_q <= 1'b1;
          end else if (key_bad) begin
            err_q <= 1'b1;
            if (fail_q < MAX_FAIL_C) fail_q <= fail_q + 3'd1;
          end else begin
            err_q  <= 1'b0;
            fail_q <= 3'd0;
          end
        end
        S_MODE: cnt_q <= RD_LAT_M1;
        S_WAIT_RD: begin
          if (cnt_q == 2'd0) rdata_q <= mem_rdata;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        S_RESP: cnt_q <= GAP_M1;
        S_GAP: if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_mem_host.sv
// Testbench for secure_mem_host: directed scenarios plus randomized requests
// checked cycle by cycle against a transaction-level model of the host.
module tb_secure_mem_host;
  localparam logic [5:0] RAM_KEY  = 6'h3F;
  localparam logic [5:0] ROM_KEY  = 6'h3E;
  localparam int         MAX_FAIL = 3;
  localparam int         RD_LAT   = 1;
  localparam int         GAP_CYC  = 1;

  logic       clk, rst;
  logic       req_valid, req_ready, req_write, req_rom, unlock;
  logic [5:0] req_key;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err, locked, mem_we, mem_re;
  logic [7:0] rsp_rdata, mem_pw, mem_data, mem_rdata;
  logic [2:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int model_fail = 0;

  secure_mem_host #(
    .RAM_KEY(RAM_KEY), .ROM_KEY(ROM_KEY), .MAX_FAIL(MAX_FAIL),
    .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_rom(req_rom), .req_key(req_key), .req_wdata(req_wdata),
    .unlock(unlock),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .locked(locked), .fail_cnt(fail_cnt),
    .mem_pw(mem_pw), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req_ready, rsp_valid, rsp_err, rsp_rdata, locked, fail_cnt, mem_pw, mem_data, mem_we, mem_re}
  function automatic logic [32:0] obs();
    return {req_ready, rsp_valid, rsp_err, rsp_rdata, locked, fail_cnt,
            mem_pw, mem_data, mem_we, mem_re};
  endfunction

  // One request from the cycle it is offered to the cycle the block is ready
  // again. Cycle 0 is the cycle whose closing edge accepts the request.
  task automatic run_req(input bit w, input bit rm, input logic [5:0] k,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input bit with_unlock, input string name);
    bit err, bus;
    int rsp_c, rdy_c, fail_old, waited, last_bus;
    logic [2:0] f;
    logic [7:0] pw;
    logic [32:0] exp_v, obs_v;
    req_write = w; req_rom = rm; req_key = k; req_wdata = wd; req_valid = 1'b1;
    if (with_unlock) begin
      unlock = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s unlock_ready: got %b exp 0", name, req_ready);
      end
      @(posedge clk); @(negedge clk);
      unlock = 1'b0;
      model_fail = 0;
      #1;
      checks++;
      if ({fail_cnt, locked} !== 4'b0000) begin
        errors++;
        $display("FAIL %s unlock_clear: got fail_cnt=%0d locked=%b exp 0/0", name, fail_cnt, locked);
      end
    end
    #1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); @(negedge clk); #1;
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: got req_ready=%b exp 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    fail_old = model_fail;
    err = (model_fail == MAX_FAIL) || (k != (rm ? ROM_KEY : RAM_KEY));
    if (!err) model_fail = 0;
    else if (model_fail < MAX_FAIL) model_fail++;
    rsp_c = err ? 2 : (w ? 5 : 4 + RD_LAT);
    rdy_c = err ? 3 : rsp_c + 1 + GAP_CYC;
    last_bus = w ? 4 : 3 + RD_LAT;
    pw = {~rm, ~w, k};
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= rdy_c; c++) begin
      @(negedge clk);
      mem_rdata = (c == 3 + RD_LAT) ? rd : 8'($urandom);
      #1;
      bus = !err && c >= 2 && c <= last_bus;
      f = 3'((c >= 2) ? model_fail : fail_old);
      exp_v = {c == rdy_c, c == rsp_c, c == rsp_c && err,
               (c == rsp_c && !err && !w) ? rd : 8'h00,
               f == 3'(MAX_FAIL), f,
               bus ? pw : 8'h00, bus ? wd : 8'h00,
               bus && w && c == 4, bus && !w && c == 3};
      obs_v = obs();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle%0d: got %h exp %h", name, c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (obs() !== 33'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", obs());
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b fail_cnt=%0d exp 1/0", req_ready, fail_cnt);
    end
    model_fail = 0;
  endtask

  task automatic test_write_ram();
    run_req(1'b1, 1'b0, 6'h3F, 8'hA5, 8'h00, 1'b0, "write_ram");
  endtask

  task automatic test_read_rom();
    run_req(1'b0, 1'b1, 6'h3E, 8'h00, 8'h5C, 1'b0, "read_rom");
  endtask

  task automatic test_lockout();
    run_req(1'b1, 1'b0, 6'h00, 8'h11, 8'h00, 1'b0, "bad_key1");
    run_req(1'b1, 1'b0, 6'h00, 8'h22, 8'h00, 1'b0, "bad_key2");
    run_req(1'b1, 1'b0, 6'h00, 8'h33, 8'h00, 1'b0, "bad_key3");
    run_req(1'b1, 1'b0, 6'h3F, 8'h44, 8'h00, 1'b0, "locked_good_key");
    run_req(1'b1, 1'b0, 6'h3F, 8'h55, 8'h00, 1'b1, "unlock_then_write");
  endtask

  task automatic test_bad_then_good();
    run_req(1'b0, 1'b1, 6'h3F, 8'h00, 8'h00, 1'b0, "bad_rom_key");
    run_req(1'b0, 1'b0, 6'h3F, 8'h00, 8'hC3, 1'b0, "good_read");
  endtask

  task automatic test_reset_mid();
    run_req(1'b1, 1'b1, 6'h01, 8'h00, 8'h00, 1'b0, "pre_reset_bad");
    req_write = 1'b0; req_rom = 1'b1; req_key = 6'h3E; req_wdata = 8'h99;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (mem_re !== 1'b1 || mem_pw !== 8'h7E) begin
      errors++;
      $display("FAIL mid_mode: got re=%b pw=%h exp 1/7e", mem_re, mem_pw);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 33'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h exp 0", obs());
    end
    model_fail = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b exp 1", req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || mem_re !== 1'b0 || fail_cnt !== 3'd0) begin
        errors++;
        $display("FAIL mid_reset_quiet%0d: got rsp=%b re=%b fail=%0d exp 0/0/0", c, rsp_valid, mem_re, fail_cnt);
      end
    end
  endtask

  task automatic test_random();
    bit w, rm, ul;
    logic [5:0] k;
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      rm = 1'($urandom);
      k  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (rm ? ROM_KEY : RAM_KEY);
      ul = (model_fail == MAX_FAIL && $urandom_range(0, 1) == 1) || $urandom_range(0, 9) == 0;
      run_req(w, rm, k, 8'($urandom), 8'($urandom), ul, "random");
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_rom = 1'b0;
    req_key = 6'h00; req_wdata = 8'h00; unlock = 1'b0; mem_rdata = 8'h00;
    test_reset();
    test_write_ram();
    test_read_rom();
    test_lockout();
    test_bad_then_good();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
